// File: rtl/aes128_stream_ctrl.sv
// ---------------------------------------------------------------------------
// aes128_stream_ctrl
//
// Stream front-end for aes128_core. Packs four 32-bit input words into a
// 128-bit plaintext block, launches the core with a one-cycle start pulse,
// captures the ciphertext on core_done_i and unpacks it into four 32-bit
// output words. Filling the next input block overlaps with encryption and
// draining, so blocks can stream back to back.
//
// Word order: the first word of a block occupies bits [127:96] and the
// fourth word occupies [31:0]. The output side emits [127:96] first.
//
// Optional feature (macro AES_CBC_EN):
//   Defined   - CBC chaining. The plaintext is XORed with a chain register
//               at launch. The chain register is loaded from iv_i by
//               iv_load_i while idle and takes each ciphertext on done.
//   Undefined - ECB. iv_i and iv_load_i are ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   key_i               AES key, sampled at launch
//   iv_i, iv_load_i     CBC initial vector and its load strobe
//   s_data_i/s_valid_i/s_ready_o   input word stream
//   m_data_o/m_valid_o/m_ready_i   output word stream
//   core_start_o        one-cycle start pulse to the core (registered)
//   core_key_o          key to the core, held from launch to next launch
//   core_pt_o           plaintext to the core, held from launch to next launch
//   core_ct_i           ciphertext from the core
//   core_ready_i        core idle
//   core_done_i         core result valid this cycle
//   busy_o              block in flight (LAUNCH or WAIT)
//
// N_WORDS must stay 4; it only names the block size in the counters.
// ---------------------------------------------------------------------------
module aes128_stream_ctrl #(
    parameter int N_WORDS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_i,
    input  logic [127:0] iv_i,
    input  logic         iv_load_i,
    input  logic [31:0]  s_data_i,
    input  logic         s_valid_i,
    output logic         s_ready_o,
    output logic [31:0]  m_data_o,
    output logic         m_valid_o,
    input  logic         m_ready_i,
    output logic         core_start_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_pt_o,
    input  logic [127:0] core_ct_i,
    input  logic         core_ready_i,
    input  logic         core_done_i,
    output logic         busy_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;

    localparam logic [2:0] FULL = 3'(N_WORDS);

    logic [1:0]   state;
    logic [2:0]   in_cnt;
    logic [2:0]   out_cnt;
    logic [127:0] in_buf;
    logic [127:0] out_buf;
    logic [127:0] pt_next;
    logic         s_fire;
    logic         m_fire;
    logic         launch;

    // A full input buffer refuses further words; this is what turns a
    // stalled output side into backpressure on the input side.
    assign s_ready_o = (in_cnt != FULL);
    assign s_fire    = s_valid_i && s_ready_o;

    assign m_valid_o = (out_cnt != 3'd0);
    assign m_fire    = m_valid_o && m_ready_i;
    assign m_data_o  = out_buf[127:96];

    assign busy_o = (state != IDLE);

    // Launch only once the previous result has fully drained, so the single
    // output buffer can never be overwritten by the next ciphertext.
    assign launch = (state == IDLE) && (in_cnt == FULL) && (out_cnt == 3'd0);

`ifdef AES_CBC_EN
    logic [127:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else if (state == IDLE && iv_load_i) begin
            chain <= iv_i;
        end else if (state == WAIT && core_done_i) begin
            chain <= core_ct_i;
        end
    end

    assign pt_next = in_buf ^ chain;
`else
    // ECB build: the IV ports exist for a uniform interface but have no use.
    logic unused_iv;
    assign unused_iv = ^{iv_i, iv_load_i};

    assign pt_next = in_buf;
`endif

    // NOTE: all state below is updated with non-blocking assignments so that
    // every right-hand side reads the pre-edge value; later assignments in
    // the block deliberately override earlier ones for the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_cnt       <= 3'd0;
            in_buf       <= '0;
            out_cnt      <= 3'd0;
            out_buf      <= '0;
            core_start_o <= 1'b0;
            core_pt_o    <= '0;
            core_key_o   <= '0;
        end else begin
            core_start_o <= 1'b0;

            // Shifting in from the bottom leaves the first word at [127:96]
            // once four words have arrived.
            if (s_fire) begin
                in_buf <= {in_buf[95:0], s_data_i};
                in_cnt <= in_cnt + 3'd1;
            end

            if (m_fire) begin
                out_buf <= {out_buf[95:0], 32'd0};
                out_cnt <= out_cnt - 3'd1;
            end

            case (state)
                IDLE: begin
                    if (launch) begin
                        core_pt_o  <= pt_next;
                        core_key_o <= key_i;
                        in_cnt     <= 3'd0;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // Hold here without a pulse until the core is idle.
                    if (core_ready_i) begin
                        core_start_o <= 1'b1;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    // out_cnt is zero throughout LAUNCH/WAIT, so no drain
                    // handshake can collide with this load.
                    if (core_done_i) begin
                        out_buf <= core_ct_i;
                        out_cnt <= FULL;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/aes128_stream_ctrl.md
Name: aes128_stream_ctrl

Overview:
Stream front-end for aes128_core. It packs 32-bit input words into 128-bit plaintext blocks and launches the core with a start pulse. It captures the ciphertext when the core signals done, then unpacks it into 32-bit output words. Input filling overlaps with encryption and draining, so blocks can stream back to back.

Parameters:
- N_WORDS, 4, words per block. Fixed at 4; any other value is illegal. Present only for readability of counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- key_i  in  128  AES key; sampled at launch
- iv_i  in  128  CBC initial vector
- iv_load_i  in  1  load iv_i into chain register
- s_data_i  in  32  input word
- s_valid_i  in  1  input word valid
- s_ready_o  out  1  input word accepted when s_valid_i && s_ready_o
- m_data_o  out  32  output word
- m_valid_o  out  1  output word valid
- m_ready_i  in  1  output word consumed when m_valid_o && m_ready_i
- core_start_o  out  1  one-cycle start pulse to core
- core_key_o  out  128  key to core, registered
- core_pt_o  out  128  plaintext to core, registered
- core_ct_i  in  128  ciphertext from core
- core_ready_i  in  1  core idle
- core_done_i  in  1  core result valid this cycle
- busy_o  out  1  block in flight (LAUNCH or WAIT)

Behaviour:
- Word order:
  - First input word maps to bits [127:96]; the 4th word maps to [31:0].
  - Output uses the same order: the word from [127:96] is emitted first.
- Input side:
  - 3-bit in_cnt, 128-bit in_buf.
  - s_ready_o = (in_cnt != 4), combinational. It reads 1 during reset.
  - Each accepted word is stored and in_cnt increments.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE -> LAUNCH when in_cnt==4 && out_cnt==0.
    - On that edge: core_pt_o <= in_buf (XOR chain, see feature); core_key_o <= key_i; in_cnt <= 0.
    - The input buffer accepts the next block from the following cycle.
  - LAUNCH: core_start_o = 1 for exactly the cycle(s) in which core_ready_i = 1. On that cycle go to WAIT. While core_ready_i = 0, stay in LAUNCH with core_start_o = 0.
  - WAIT -> IDLE on the cycle core_done_i = 1. That cycle: out_buf <= core_ct_i; out_cnt <= 4.
- core_start_o is registered, so it is high for exactly one clk per block.
- core_pt_o and core_key_o are held stable from launch until the next launch.
- core_done_i is ignored in IDLE and LAUNCH.
- Output side:
  - m_valid_o = (out_cnt != 0).
  - m_data_o = out_buf[127:96].
  - On a handshake: out_buf shifts left by 32 and out_cnt decrements.
  - Holding m_ready_i = 0 stalls the drain indefinitely. It also blocks the next launch, and in_cnt saturates at 4, giving backpressure to the input.
- Latency: last input word to first output word = 2 + core latency + 1 cycles, with the core ready and the output empty.
- Simultaneous events:
  - An input accept on the launch edge is illegal; it cannot occur because s_ready_o = 0 when in_cnt = 4.
  - A handshake on the last output word plus in_cnt==4 launches on the following cycle.
- Reset:
  - Asynchronous. All state goes to 0 and the FSM to IDLE.
  - m_valid_o = 0, core_start_o = 0, busy_o = 0, core_pt_o = 0, core_key_o = 0, m_data_o = 0.
  - Reset mid-WAIT discards the block. A later stray core_done_i is ignored.
- busy_o = (state != IDLE).

Optional Feature:
- Macro AES_CBC_EN.
- Defined:
  - A 128-bit chain register, reset value 0.
  - iv_load_i = 1 in IDLE loads chain <= iv_i. It is ignored in LAUNCH and WAIT.
  - At launch, core_pt_o <= in_buf ^ chain.
  - On core_done_i in WAIT, chain <= core_ct_i.
- Undefined: core_pt_o <= in_buf. iv_i and iv_load_i are ignored, and no chain register is built.

Test Plan:
- ECB FIPS-197 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f; words 00112233, 44556677, 8899aabb, ccddeeff.
  - Required: one core_start_o pulse; core_pt_o = 00112233_44556677_8899aabb_ccddeeff; outputs 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, in order.
- Output backpressure:
  - Stimulus: m_ready_i = 0 for 20 cycles after done, with 8 input words offered.
  - Required: m_data_o holds 69c4e0d8; in_cnt saturates at 4; s_ready_o = 0; no second start pulse until all 4 output words drain.
- Back-to-back:
  - Stimulus: 8 words pushed continuously.
  - Required: second-block words are accepted during WAIT; exactly 2 start pulses; 8 output words in order.
- Core not ready:
  - Stimulus: core_ready_i = 0 for 10 cycles at launch.
  - Required: core_start_o stays 0 and busy_o = 1; start pulses on the first cycle core_ready_i = 1.
- CBC (AES_CBC_EN):
  - Stimulus: iv 0 loaded; block 1 = FIPS plaintext, block 2 = all-zero words.
  - Required: block-1 output matches ECB; block-2 core_pt_o = 69c4e0d8_6a7b0430_d8cdb780_70b4c55a.
- Reset mid-WAIT:
  - Stimulus: rst_n low for 2 cycles, then core_done_i pulsed.
  - Required: m_valid_o stays 0, busy_o = 0, no output words, s_ready_o = 1.
